// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : reorder_buffer
// Description : Circular Tomasulo reorder buffer with dual-CDB capture,
//               operand lookup with CDB bypass, and in-order retirement.
// Revision    : 1.0 - initial release
// ============================================================================
module reorder_buffer #(
  parameter int         DEPTH       = 32,
  parameter int         PTR_W       = 5,
  parameter logic [5:0] INVALID_TAG = 6'b100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        alloc_valid,
  input  logic [4:0]  alloc_dest,
  output logic        alloc_ready,
  output logic [5:0]  alloc_tag,
  input  logic        CDBiscast,
  input  logic [5:0]  CDBrobNum,
  input  logic [31:0] CDBdata,
  input  logic        CDBiscast2,
  input  logic [5:0]  CDBrobNum2,
  input  logic [31:0] CDBdata2,
  input  logic [5:0]  index,
  output logic        ready,
  output logic [31:0] value,
  output logic        commit_valid,
  output logic [4:0]  commit_reg,
  output logic [31:0] commit_data,
  output logic [5:0]  commit_tag,
  output logic [5:0]  count
);
  localparam int TAG_W = 6;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] done_q, done_d;
  logic [4:0]       dest_q [DEPTH];
  logic [4:0]       dest_d [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [TAG_W-1:0] count_q, count_d;
  logic             commit_valid_q, commit_valid_d;
  logic [4:0]       commit_reg_q, commit_reg_d;
  logic [31:0]      commit_data_q, commit_data_d;
  logic [TAG_W-1:0] commit_tag_q, commit_tag_d;

  logic             w_alloc;
  logic             w_commit;
  logic             w_idx_ok;
  logic [PTR_W-1:0] w_lk;

  assign alloc_ready = (32'(count_q) < DEPTH);
  assign alloc_tag   = TAG_W'(tail_q);
  assign w_alloc     = alloc_valid & alloc_ready;
  assign w_commit    = busy_q[head_q] & done_q[head_q];

  always_comb begin
    busy_d         = busy_q;
    done_d         = done_q;
    dest_d         = dest_q;
    data_d         = data_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    commit_valid_d = w_commit;
    commit_reg_d   = commit_reg_q;
    commit_data_d  = commit_data_q;
    commit_tag_d   = commit_tag_q;

    // Capture uses pre-edge state, so a result written now retires no earlier than next edge
    for (int i = 0; i < DEPTH; i++) begin
      if (busy_q[i] && !done_q[i]) begin
        if (CDBiscast && CDBrobNum == TAG_W'(i)) begin
          done_d[i] = 1'b1;
          data_d[i] = CDBdata;
        end else if (CDBiscast2 && CDBrobNum2 == TAG_W'(i)) begin
          done_d[i] = 1'b1;
          data_d[i] = CDBdata2;
        end
      end
    end

    if (w_commit) begin
      busy_d[head_q] = 1'b0;
      done_d[head_q] = 1'b0;
      commit_reg_d   = dest_q[head_q];
      commit_data_d  = data_q[head_q];
      commit_tag_d   = TAG_W'(head_q);
      head_d         = (head_q == PTR_W'(DEPTH - 1)) ? '0 : head_q + PTR_W'(1);
    end

    if (w_alloc) begin
      busy_d[tail_q] = 1'b1;
      done_d[tail_q] = 1'b0;
      dest_d[tail_q] = alloc_dest;
      data_d[tail_q] = '0;
      tail_d         = (tail_q == PTR_W'(DEPTH - 1)) ? '0 : tail_q + PTR_W'(1);
    end

    case ({w_alloc, w_commit})
      2'b10:   count_d = count_q + TAG_W'(1);
      2'b01:   count_d = count_q - TAG_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q         <= '0;
      done_q         <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_reg_q   <= '0;
      commit_data_q  <= '0;
      commit_tag_q   <= INVALID_TAG;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      busy_q         <= busy_d;
      done_q         <= done_d;
      dest_q         <= dest_d;
      data_q         <= data_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_reg_q   <= commit_reg_d;
      commit_data_q  <= commit_data_d;
      commit_tag_q   <= commit_tag_d;
    end
  end

  assign w_idx_ok = (32'(index) < DEPTH);
  assign w_lk     = index[PTR_W-1:0];

  // Operand lookup, bypassing same-cycle CDB results with port 1 priority
  always_comb begin
    ready = 1'b0;
    value = '0;
    if (w_idx_ok && busy_q[w_lk]) begin
      if (done_q[w_lk]) begin
        ready = 1'b1;
        value = data_q[w_lk];
      end else if (CDBiscast && CDBrobNum == index) begin
        ready = 1'b1;
        value = CDBdata;
      end else if (CDBiscast2 && CDBrobNum2 == index) begin
        ready = 1'b1;
        value = CDBdata2;
      end
    end
  end

  assign commit_valid = commit_valid_q;
  assign commit_reg   = commit_reg_q;
  assign commit_data  = commit_data_q;
  assign commit_tag   = commit_tag_q;
  assign count        = count_q;

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reorder_buffer
// Description : Self-checking bench for reorder_buffer against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        alloc_valid = 1'b0;
  logic [4:0]  alloc_dest = '0;
  logic        alloc_ready;
  logic [5:0]  alloc_tag;
  logic        CDBiscast = 1'b0;
  logic [5:0]  CDBrobNum = '0;
  logic [31:0] CDBdata = '0;
  logic        CDBiscast2 = 1'b0;
  logic [5:0]  CDBrobNum2 = '0;
  logic [31:0] CDBdata2 = '0;
  logic [5:0]  index = '0;
  logic        ready;
  logic [31:0] value;
  logic        commit_valid;
  logic [4:0]  commit_reg;
  logic [31:0] commit_data;
  logic [5:0]  commit_tag;
  logic [5:0]  count;

  int n_pass  = 0;
  int n_total = 0;

  reorder_buffer dut (
    .clock(clock), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_dest(alloc_dest),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .CDBiscast(CDBiscast), .CDBrobNum(CDBrobNum), .CDBdata(CDBdata),
    .CDBiscast2(CDBiscast2), .CDBrobNum2(CDBrobNum2), .CDBdata2(CDBdata2),
    .index(index), .ready(ready), .value(value),
    .commit_valid(commit_valid), .commit_reg(commit_reg),
    .commit_data(commit_data), .commit_tag(commit_tag), .count(count)
  );

  always #5 clock = ~clock;

  // Reference model: in-flight instructions in program order
  typedef struct packed {
    logic [5:0]  tag;
    logic [4:0]  dest;
    logic        done;
    logic [31:0] data;
  } ent_t;

  ent_t        m_q[$];
  int          m_tail;
  logic        m_cv;
  logic [4:0]  m_creg;
  logic [31:0] m_cdata;
  logic [5:0]  m_ctag;

  function automatic void model_reset();
    m_q.delete();
    m_tail  = 0;
    m_cv    = 1'b0;
    m_creg  = '0;
    m_cdata = '0;
    m_ctag  = 6'd32;
  endfunction

  function automatic void model_update();
    bit   can_alloc;
    ent_t e;
    can_alloc = (m_q.size() < 32);
    if (m_q.size() > 0 && m_q[0].done) begin
      m_cv    = 1'b1;
      m_creg  = m_q[0].dest;
      m_cdata = m_q[0].data;
      m_ctag  = m_q[0].tag;
      void'(m_q.pop_front());
    end else begin
      m_cv = 1'b0;
    end
    foreach (m_q[i]) begin
      if (!m_q[i].done) begin
        if (CDBiscast && CDBrobNum == m_q[i].tag) begin
          m_q[i].done = 1'b1; m_q[i].data = CDBdata;
        end else if (CDBiscast2 && CDBrobNum2 == m_q[i].tag) begin
          m_q[i].done = 1'b1; m_q[i].data = CDBdata2;
        end
      end
    end
    if (alloc_valid && can_alloc) begin
      e.tag = 6'(m_tail); e.dest = alloc_dest; e.done = 1'b0; e.data = '0;
      m_q.push_back(e);
      m_tail = (m_tail + 1) % 32;
    end
  endfunction

  function automatic void m_lookup(input logic [5:0] idx, output logic rdy, output logic [31:0] val);
    rdy = 1'b0;
    val = '0;
    foreach (m_q[i]) begin
      if (m_q[i].tag == idx) begin
        if (m_q[i].done) begin
          rdy = 1'b1; val = m_q[i].data;
        end else if (CDBiscast && CDBrobNum == idx) begin
          rdy = 1'b1; val = CDBdata;
        end else if (CDBiscast2 && CDBrobNum2 == idx) begin
          rdy = 1'b1; val = CDBdata2;
        end
      end
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic set_idle();
    alloc_valid = 1'b0; alloc_dest = '0;
    CDBiscast = 1'b0; CDBrobNum = '0; CDBdata = '0;
    CDBiscast2 = 1'b0; CDBrobNum2 = '0; CDBdata2 = '0;
    index = '0;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) begin
      alloc_valid = 1'b1;
      alloc_dest  = 5'(i + 1);
      tick();
    end
    alloc_valid = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    n_total++; if (count !== 6'd0) $display("FAIL rst_count: got %0d want 0", count); else n_pass++;
    n_total++; if (alloc_ready !== 1'b1) $display("FAIL rst_alloc_ready: got %b want 1", alloc_ready); else n_pass++;
    n_total++; if (alloc_tag !== 6'd0) $display("FAIL rst_alloc_tag: got %0d want 0", alloc_tag); else n_pass++;
    n_total++; if (commit_valid !== 1'b0) $display("FAIL rst_commit_valid: got %b want 0", commit_valid); else n_pass++;
    n_total++; if (commit_tag !== 6'd32) $display("FAIL rst_commit_tag: got %0d want 32", commit_tag); else n_pass++;
    n_total++; if (commit_reg !== 5'd0 || commit_data !== 32'd0)
      $display("FAIL rst_commit_regdata: got %0d/%h want 0/0", commit_reg, commit_data); else n_pass++;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    alloc_valid = 1'b1; alloc_dest = 5'd5;
    #1;
    n_total++; if (alloc_tag !== 6'd0) $display("FAIL basic_alloc_tag: got %0d want 0", alloc_tag); else n_pass++;
    tick();
    alloc_valid = 1'b0;
    n_total++; if (count !== 6'd1) $display("FAIL basic_count1: got %0d want 1", count); else n_pass++;
    CDBiscast = 1'b1; CDBrobNum = 6'd0; CDBdata = 32'h1234; index = 6'd0;
    #1;
    n_total++; if (ready !== 1'b1 || value !== 32'h1234)
      $display("FAIL basic_bypass: got %b/%h want 1/00001234", ready, value); else n_pass++;
    tick();
    CDBiscast = 1'b0;
    n_total++; if (commit_valid !== 1'b0) $display("FAIL basic_early_commit: got %b want 0", commit_valid); else n_pass++;
    tick();
    n_total++; if (commit_valid !== 1'b1 || commit_reg !== 5'd5 || commit_data !== 32'h1234 || commit_tag !== 6'd0)
      $display("FAIL basic_commit: got v%b r%0d d%h t%0d want v1 r5 d00001234 t0",
               commit_valid, commit_reg, commit_data, commit_tag); else n_pass++;
    n_total++; if (count !== 6'd0) $display("FAIL basic_count0: got %0d want 0", count); else n_pass++;
    tick();
    n_total++; if (commit_valid !== 1'b0 || commit_data !== 32'h1234)
      $display("FAIL basic_hold: got v%b d%h want v0 d00001234", commit_valid, commit_data); else n_pass++;
  endtask

  task automatic test_in_order();
    do_reset();
    alloc_n(2);
    CDBiscast = 1'b1; CDBrobNum = 6'd1; CDBdata = 32'd7;
    tick();
    CDBrobNum = 6'd0; CDBdata = 32'd9;
    tick();
    CDBiscast = 1'b0;
    n_total++; if (commit_valid !== 1'b0) $display("FAIL order_none: got %b want 0", commit_valid); else n_pass++;
    tick();
    n_total++; if (commit_valid !== 1'b1 || commit_tag !== 6'd0 || commit_data !== 32'd9 || commit_reg !== 5'd1)
      $display("FAIL order_first: got v%b t%0d d%0d r%0d want v1 t0 d9 r1",
               commit_valid, commit_tag, commit_data, commit_reg); else n_pass++;
    tick();
    n_total++; if (commit_valid !== 1'b1 || commit_tag !== 6'd1 || commit_data !== 32'd7 || commit_reg !== 5'd2)
      $display("FAIL order_second: got v%b t%0d d%0d r%0d want v1 t1 d7 r2",
               commit_valid, commit_tag, commit_data, commit_reg); else n_pass++;
    tick();
    n_total++; if (commit_valid !== 1'b0 || count !== 6'd0)
      $display("FAIL order_end: got v%b c%0d want v0 c0", commit_valid, count); else n_pass++;
  endtask

  task automatic test_full();
    do_reset();
    alloc_n(32);
    alloc_valid = 1'b1; alloc_dest = 5'd3;
    #1;
    n_total++; if (alloc_ready !== 1'b0 || count !== 6'd32 || alloc_tag !== 6'd0)
      $display("FAIL full_state: got rdy%b c%0d t%0d want rdy0 c32 t0", alloc_ready, count, alloc_tag); else n_pass++;
    tick();
    n_total++; if (count !== 6'd32 || alloc_tag !== 6'd0)
      $display("FAIL full_drop: got c%0d t%0d want c32 t0", count, alloc_tag); else n_pass++;
    alloc_valid = 1'b0;
    CDBiscast = 1'b1; CDBrobNum = 6'd0; CDBdata = 32'hF00;
    tick();
    CDBiscast = 1'b0;
    alloc_valid = 1'b1; alloc_dest = 5'd9;
    #1;
    n_total++; if (alloc_ready !== 1'b0) $display("FAIL full_same_cycle_ready: got %b want 0", alloc_ready); else n_pass++;
    tick();
    n_total++; if (commit_valid !== 1'b1 || commit_tag !== 6'd0 || commit_data !== 32'hF00 || count !== 6'd31)
      $display("FAIL full_commit: got v%b t%0d d%h c%0d want v1 t0 d00000f00 c31",
               commit_valid, commit_tag, commit_data, count); else n_pass++;
    n_total++; if (alloc_ready !== 1'b1 || alloc_tag !== 6'd0)
      $display("FAIL full_wrap_tag: got rdy%b t%0d want rdy1 t0", alloc_ready, alloc_tag); else n_pass++;
    tick();
    alloc_valid = 1'b0;
    index = 6'd0;
    #1;
    n_total++; if (count !== 6'd32 || alloc_tag !== 6'd1 || ready !== 1'b0)
      $display("FAIL full_realloc: got c%0d t%0d rdy%b want c32 t1 rdy0", count, alloc_tag, ready); else n_pass++;
  endtask

  task automatic test_dual_cdb();
    do_reset();
    alloc_n(4);
    CDBiscast  = 1'b1; CDBrobNum  = 6'd3; CDBdata  = 32'hA;
    CDBiscast2 = 1'b1; CDBrobNum2 = 6'd3; CDBdata2 = 32'hB;
    index = 6'd3;
    #1;
    n_total++; if (ready !== 1'b1 || value !== 32'hA)
      $display("FAIL dual_bypass: got %b/%h want 1/0000000a", ready, value); else n_pass++;
    tick();
    CDBiscast = 1'b0; CDBiscast2 = 1'b0;
    #1;
    n_total++; if (ready !== 1'b1 || value !== 32'hA)
      $display("FAIL dual_stored: got %b/%h want 1/0000000a", ready, value); else n_pass++;
    CDBiscast  = 1'b1; CDBrobNum  = 6'd1; CDBdata  = 32'hD;
    CDBiscast2 = 1'b1; CDBrobNum2 = 6'd2; CDBdata2 = 32'hC;
    index = 6'd2;
    #1;
    n_total++; if (ready !== 1'b1 || value !== 32'hC)
      $display("FAIL port2_bypass: got %b/%h want 1/0000000c", ready, value); else n_pass++;
    tick();
    CDBiscast = 1'b0; CDBiscast2 = 1'b0;
    index = 6'd1;
    #1;
    n_total++; if (ready !== 1'b1 || value !== 32'hD)
      $display("FAIL port1_stored: got %b/%h want 1/0000000d", ready, value); else n_pass++;
    index = 6'd2;
    #1;
    n_total++; if (ready !== 1'b1 || value !== 32'hC)
      $display("FAIL port2_stored: got %b/%h want 1/0000000c", ready, value); else n_pass++;
  endtask

  task automatic test_lookup_invalid();
    do_reset();
    alloc_n(9);
    index = 6'd32;
    #1;
    n_total++; if (ready !== 1'b0 || value !== 32'd0)
      $display("FAIL lk_invalid_tag: got %b/%h want 0/0", ready, value); else n_pass++;
    index = 6'd4;
    #1;
    n_total++; if (ready !== 1'b0) $display("FAIL lk_undone: got %b want 0", ready); else n_pass++;
    index = 6'd20;
    #1;
    n_total++; if (ready !== 1'b0) $display("FAIL lk_not_busy: got %b want 0", ready); else n_pass++;
    CDBiscast  = 1'b1; CDBrobNum  = 6'd40; CDBdata  = 32'hDEAD;
    CDBiscast2 = 1'b1; CDBrobNum2 = 6'd41; CDBdata2 = 32'hBEEF;
    index = 6'd8;
    #1;
    n_total++; if (ready !== 1'b0) $display("FAIL lk_oob_bypass: got %b want 0", ready); else n_pass++;
    tick();
    CDBiscast = 1'b0; CDBiscast2 = 1'b0;
    #1;
    n_total++; if (ready !== 1'b0 || count !== 6'd9)
      $display("FAIL oob_capture: got rdy%b c%0d want rdy0 c9", ready, count); else n_pass++;
    index = 6'd40;
    #1;
    n_total++; if (ready !== 1'b0 || value !== 32'd0)
      $display("FAIL lk_tag40: got %b/%h want 0/0", ready, value); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    alloc_n(4);
    CDBiscast  = 1'b1; CDBrobNum  = 6'd1; CDBdata  = 32'h11;
    CDBiscast2 = 1'b1; CDBrobNum2 = 6'd2; CDBdata2 = 32'h22;
    tick();
    set_idle();
    n_total++; if (count !== 6'd4) $display("FAIL mid_pre_count: got %0d want 4", count); else n_pass++;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    n_total++; if (count !== 6'd0 || commit_valid !== 1'b0 || alloc_ready !== 1'b1 || alloc_tag !== 6'd0)
      $display("FAIL mid_async: got c%0d v%b rdy%b t%0d want c0 v0 rdy1 t0",
               count, commit_valid, alloc_ready, alloc_tag); else n_pass++;
    @(posedge clock);
    #1;
    reset = 1'b0;
    CDBiscast = 1'b1; CDBrobNum = 6'd0; CDBdata = 32'h5;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++; if (commit_valid !== 1'b0 || count !== 6'd0)
        $display("FAIL mid_after_%0d: got v%b c%0d want v0 c0", i, commit_valid, count); else n_pass++;
    end
    set_idle();
  endtask

  task automatic test_random();
    logic        e_rdy;
    logic [31:0] e_val;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      int alloc_pct;
      alloc_pct   = ((cyc / 300) % 2 == 0) ? 90 : 30;
      alloc_valid = ($urandom_range(99) < alloc_pct);
      alloc_dest  = 5'($urandom);
      CDBiscast   = ($urandom_range(99) < 55);
      CDBrobNum   = (m_q.size() > 0 && $urandom_range(3) != 0) ?
                    m_q[$urandom_range(m_q.size() - 1)].tag : 6'($urandom);
      CDBdata     = $urandom;
      CDBiscast2  = ($urandom_range(99) < 40);
      CDBrobNum2  = (m_q.size() > 0 && $urandom_range(3) != 0) ?
                    m_q[$urandom_range(m_q.size() - 1)].tag : 6'($urandom);
      CDBdata2    = $urandom;
      case ($urandom_range(3))
        0:       index = CDBrobNum;
        1:       index = CDBrobNum2;
        2:       index = (m_q.size() > 0) ? m_q[$urandom_range(m_q.size() - 1)].tag : 6'($urandom);
        default: index = 6'($urandom);
      endcase
      #1;
      m_lookup(index, e_rdy, e_val);
      n_total++; if (ready !== e_rdy || value !== e_val)
        $display("FAIL rnd_lookup c%0d idx%0d: got %b/%h want %b/%h", cyc, index, ready, value, e_rdy, e_val);
        else n_pass++;
      n_total++; if (alloc_ready !== (m_q.size() < 32) || alloc_tag !== 6'(m_tail))
        $display("FAIL rnd_alloc c%0d: got rdy%b t%0d want rdy%b t%0d", cyc, alloc_ready, alloc_tag,
                 (m_q.size() < 32), m_tail); else n_pass++;
      tick();
      n_total++; if (commit_valid !== m_cv || commit_reg !== m_creg || commit_data !== m_cdata || commit_tag !== m_ctag)
        $display("FAIL rnd_commit c%0d: got v%b r%0d d%h t%0d want v%b r%0d d%h t%0d", cyc,
                 commit_valid, commit_reg, commit_data, commit_tag, m_cv, m_creg, m_cdata, m_ctag);
        else n_pass++;
      n_total++; if (count !== 6'(m_q.size()))
        $display("FAIL rnd_count c%0d: got %0d want %0d", cyc, count, m_q.size()); else n_pass++;
    end
    set_idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_in_order();
    test_full();
    test_dual_cdb();
    test_lookup_invalid();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
